// File: rtl/io_pkg.sv
// Shared address map, status bit layout and helpers for the I/O port controller.
package io_pkg;

  localparam logic [3:0] ADDR_OUT_BASE = 4'h0;
  localparam logic [3:0] ADDR_IN_BASE  = 4'h8;
  localparam logic [3:0] ADDR_TXFIFO   = 4'hE;
  localparam logic [3:0] ADDR_STATUS   = 4'hF;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_COUNT_LSB = 3;

  // Occupancy is reported in a 5-bit field, so deep FIFOs saturate at 31.
  function automatic logic [4:0] sat_count5(input int unsigned c);
    return (c > 31) ? 5'd31 : c[4:0];
  endfunction

endpackage

// File: rtl/io_tx_fifo.sv
// Byte-wide transmit FIFO with registered storage; a push while full with no
// concurrent pop is dropped and flagged with a one-cycle push_dropped pulse.
module io_tx_fifo
  import io_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic [7:0]  wdata,
  input  logic        pop,
  output logic [7:0]  rdata,
  output logic        empty,
  output logic        full,
  output logic [AW:0] count,
  output logic        push_dropped
);

  logic [DEPTH-1:0][7:0] mem_q;
  logic [AW-1:0]         wr_q, rd_q;
  logic [AW:0]           cnt_q;
  logic                  do_push, do_pop;

  assign empty        = (cnt_q == '0);
  assign full         = (cnt_q == (AW+1)'(DEPTH));
  assign count        = cnt_q;
  assign rdata        = mem_q[rd_q];
  assign do_pop       = pop && !empty;
  // When full, a simultaneous pop frees the head slot, which is the write slot.
  assign do_push      = push && (!full || do_pop);
  assign push_dropped = push && full && !do_pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= wdata;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop) rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/io_port_controller.sv
// Memory-mapped I/O controller: output latches, registered input ports,
// a transmit FIFO and a status register on a 4-bit address bus.
module io_port_controller
  import io_pkg::*;
#(
  parameter int NUM_OUT    = 4,
  parameter int NUM_IN     = 4,
  parameter int FIFO_DEPTH = 4,
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            io_addr,
  input  logic [7:0]            io_wdata,
  output logic [7:0]            io_rdata,
  input  logic                  io_oe,
  input  logic                  io_we,
  output logic [8*NUM_OUT-1:0]  out_ports,
  input  logic [8*NUM_IN-1:0]   in_ports,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready
);

  logic [NUM_OUT-1:0][7:0] out_q;
  logic [NUM_IN-1:0][7:0]  in_q;
  logic                    ovf_q;
  logic                    fifo_empty, fifo_full, push_dropped;
  logic [AW:0]             fifo_cnt;
  logic [7:0]              status;
  logic                    fifo_push, ovf_clr;

  assign fifo_push = io_we && (io_addr == ADDR_TXFIFO);
  assign ovf_clr   = io_we && (io_addr == ADDR_STATUS) && io_wdata[ST_OVF];

  io_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push         (fifo_push),
    .wdata        (io_wdata),
    .pop          (tx_valid && tx_ready),
    .rdata        (tx_data),
    .empty        (fifo_empty),
    .full         (fifo_full),
    .count        (fifo_cnt),
    .push_dropped (push_dropped)
  );

  assign tx_valid  = !fifo_empty;
  assign out_ports = out_q;

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)                                              out_q[k] <= '0;
      else if (io_we && (io_addr == ADDR_OUT_BASE + 4'(k)))    out_q[k] <= io_wdata;
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      in_q <= in_ports;
      if (push_dropped)  ovf_q <= 1'b1;
      else if (ovf_clr)  ovf_q <= 1'b0;
    end
  end

  assign status = {sat_count5(32'(fifo_cnt)), ovf_q, fifo_full, fifo_empty};

  always_comb begin
    io_rdata = 8'h00;
    if (io_oe) begin
      for (int k = 0; k < NUM_OUT; k++)
        if (io_addr == ADDR_OUT_BASE + 4'(k)) io_rdata = out_q[k];
      for (int k = 0; k < NUM_IN; k++)
        if (io_addr == ADDR_IN_BASE + 4'(k)) io_rdata = in_q[k];
      if (io_addr == ADDR_STATUS) io_rdata = status;
    end
  end

endmodule

// File: doc/io_port_controller.md
Name: io_port_controller

Overview:
- Memory-mapped I/O controller on the CPU's 4-bit-address I/O bus (io_addr/io_data/io_oe/io_we).
- Decodes the 16 I/O addresses into:
  - NUM_OUT output latches;
  - NUM_IN registered input ports;
  - a transmit FIFO with a valid/ready drain port;
  - a status register.
- Sequences CPU writes into peripherals, buffers bursts of writes so the CPU never stalls, and flags dropped data.

Parameters:
- NUM_OUT, 4, output latches at addresses 0x0..NUM_OUT-1 (max 8).
- NUM_IN, 4, input ports at addresses 0x8..0x8+NUM_IN-1 (max 6).
- FIFO_DEPTH, 4, transmit FIFO entries (power of two, ≥2).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- io_addr  in  4  I/O address from CPU.
- io_wdata  in  8  CPU write data, valid when io_we=1.
- io_rdata  out  8  read data to CPU, valid when io_oe=1.
- io_oe  in  1  CPU read strobe.
- io_we  in  1  CPU write strobe, one cycle per write.
- out_ports  out  8*NUM_OUT  output latch contents, port k at bits [8k+7:8k].
- in_ports  in  8*NUM_IN  raw peripheral inputs.
- tx_data  out  8  FIFO head byte.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  downstream accepts tx_data this cycle.

Behaviour:

Address map:
- 0x0..NUM_OUT-1: output latch, read/write.
- 0x8..: input port, read-only.
- 0xE: TX FIFO push, write-only; reads 0x00.
- 0xF: status, read; a write of 1 to bit2 clears overflow.
- All other addresses: read 0x00, writes ignored.

Reset (reset=0, immediate):
- out_ports=0, FIFO empty (tx_valid=0), tx_data=0x00.
- Input registers=0, overflow=0, io_rdata=0x00.
- Reset asserted mid-transfer discards FIFO contents; there is no partial handshake.

Output latches:
- io_we at a latch address loads io_wdata at the edge.
- out_ports reflects the new value the next cycle.

Input ports:
- in_ports sampled into registers every cycle.
- Read returns the registered value, i.e. 1-cycle latency from pin to CPU.

io_rdata:
- Combinational from io_addr when io_oe=1; 0x00 when io_oe=0.

Simultaneous io_oe and io_we:
- The write takes effect at the edge.
- io_rdata shows the pre-write value that cycle.

Status bits:
- bit0 = fifo_empty, bit1 = fifo_full, bit2 = overflow (sticky).
- bits[7:3] = occupancy count, saturating at 31.

TX FIFO:
- Push: io_we && io_addr==0xE.
- Pop: tx_valid && tx_ready.
- tx_valid=!empty; tx_data=head entry, registered storage, stable while tx_valid && !tx_ready.
- A pushed byte appears on tx_data no earlier than the cycle after the push edge; no write-through.
- Push when full with no pop: byte dropped, overflow set, count unchanged.
- Push and pop in the same cycle while full: both accepted, count unchanged, no overflow.
- Push and pop in the same cycle while non-empty: count unchanged.
- Pop when empty: impossible, since tx_valid=0.
- Pointers wrap modulo FIFO_DEPTH; count width is log2(FIFO_DEPTH)+1.

Overflow clear:
- A write to 0xF with bit2=1 clears overflow.
- If an overflowing push happens in the same cycle, set wins.

FIFO state:
- EMPTY → PARTIAL on push.
- PARTIAL → FULL when count reaches FIFO_DEPTH.
- PARTIAL → EMPTY when count reaches 0.
- FULL → PARTIAL on pop without push.
- State is derived from count; no separate encoding required.

Decomposition:
- Shared package io_pkg holds:
  - address constants ADDR_OUT_BASE=4'h0, ADDR_IN_BASE=4'h8, ADDR_TXFIFO=4'hE, ADDR_STATUS=4'hF;
  - status bit indices ST_EMPTY=0, ST_FULL=1, ST_OVF=2, ST_COUNT_LSB=3.
- Sub-module io_tx_fifo (parameter DEPTH, width 8):
  - inputs push, wdata, pop;
  - outputs rdata, empty, full, count, and a push_dropped pulse.
- Top level does decode, latches, input registers, overflow and the read mux.

Test Plan:
- Reset released, write 0x5A to addr 0x2 → out_ports[23:16]=0x5A next cycle, other latches 0x00; read addr 0x2 returns 0x5A.
- in_ports port1=0xC3 applied, read addr 0x9 one cycle later → io_rdata=0xC3; read addr 0x5 → 0x00.
- tx_ready=0, push 0x01..0x05 to 0xE with FIFO_DEPTH=4 → after the 4th push status=0x22 (count 4, full); 5th push dropped, status=0x26; release tx_ready → tx_data sequence 0x01,0x02,0x03,0x04, then tx_valid=0, status=0x05.
- FIFO full, tx_ready=1 and push 0xAA in the same cycle → count stays 4, overflow stays 0, 0xAA emerges after 0x01..0x04.
- Overflow set, write 0x04 to 0xF → status bit2=0 next cycle; repeat the clear coincident with an overflowing push → bit2 remains 1.
- reset pulled low mid-drain with 3 entries queued → tx_valid=0 and out_ports=0 immediately, without a clock edge; after release, status reads 0x01.
